// File: rtl/freepdk45_sram_1w1r_fifo_ctrl.sv
// freepdk45_sram_1w1r_fifo_ctrl
//
// Purpose:
//   FIFO controller for a 1-write/1-read FreePDK45 SRAM macro. The SRAM holds
//   up to DEPTH words. A 2-entry output skid buffer hides the one-cycle SRAM
//   read latency, so total capacity is DEPTH + 2 words.
//
// Ports:
//   clk, rstb              : sole clock, asynchronous active-low reset
//   in_valid/in_ready/in_data       : producer handshake
//   out_valid/out_ready/out_data    : consumer handshake, out_data = head word
//   csb0, wmask0, addr0, din0       : SRAM write port drive (csb0 active low)
//   csb1, addr1                     : SRAM read port drive (csb1 active low)
//   dout1                           : SRAM read data, valid the cycle after issue
//
// Optional feature (macro SRAM_FIFO_LEVEL_EN):
//   level       : registered fill level = mem_count + inflight + ob_count
//   almost_full : mem_count >= DEPTH-2
//   Without the macro neither port nor its logic exists.

module freepdk45_sram_1w1r_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WMASKS = 2
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  csb0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
`ifdef SRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  almost_full
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic [ADDR_WIDTH:0]   mem_count_nxt;
    logic                  inflight;
    logic [1:0]            ob_count;
    logic [1:0]            ob_count_after_pop;
    logic [1:0]            ob_count_nxt;
    logic [DATA_WIDTH-1:0] ob_head;
    logic [DATA_WIDTH-1:0] ob_tail;
    logic                  ready_q;
    logic [NUM_WMASKS-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [2:0]            issue_limit;

    // in_ready is registered so that it stays low throughout reset and rises
    // on the first clock edge after release; otherwise it tracks mem_count < DEPTH.
    assign in_ready  = ready_q;
    assign push      = in_valid && ready_q;
    assign out_valid = (ob_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = ob_head;

    // A read may be issued only if its data is guaranteed a free skid slot
    // when it lands: ob_count + inflight - pop < 2.
    assign occupancy   = {1'b0, ob_count} + {2'b00, inflight};
    assign issue_limit = 3'd2 + {2'b00, pop};
    assign issue       = (mem_count != '0) && (occupancy < issue_limit);

    // Write port is combinational on push; when idle, the non-select outputs
    // hold whatever they carried on the most recent push.
    assign csb0   = !push;
    assign wmask0 = push ? {NUM_WMASKS{1'b1}} : wmask0_q;
    assign addr0  = push ? wr_ptr : addr0_q;
    assign din0   = push ? in_data : din0_q;

    assign csb1  = !issue;
    assign addr1 = rd_ptr;

    always_comb begin
        mem_count_nxt = mem_count;
        if (push && !issue) begin
            mem_count_nxt = mem_count + 1'b1;
        end else if (!push && issue) begin
            mem_count_nxt = mem_count - 1'b1;
        end
    end

    assign ob_count_after_pop = ob_count - {1'b0, pop};
    assign ob_count_nxt       = ob_count_after_pop + {1'b0, inflight};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ready_q   <= 1'b0;
            mem_count <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            inflight  <= 1'b0;
            ob_count  <= 2'd0;
            ob_head   <= '0;
            ob_tail   <= '0;
            wmask0_q  <= '0;
            addr0_q   <= '0;
            din0_q    <= '0;
        end else begin
            ready_q   <= (mem_count_nxt != DEPTH);
            mem_count <= mem_count_nxt;
            inflight  <= issue;
            ob_count  <= ob_count_nxt;
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                wmask0_q <= {NUM_WMASKS{1'b1}};
                addr0_q  <= wr_ptr;
                din0_q   <= in_data;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Pop shifts the tail forward; landing read data then goes into the
            // first free slot after that shift (later assignment wins on ob_head).
            if (pop) begin
                ob_head <= ob_tail;
            end
            if (inflight) begin
                if (ob_count_after_pop == 2'd0) begin
                    ob_head <= dout1;
                end else begin
                    ob_tail <= dout1;
                end
            end
        end
    end

`ifdef SRAM_FIFO_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AF_THRESH = DEPTH - (ADDR_WIDTH+1)'(2);

    logic [ADDR_WIDTH+1:0] level_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            level_q <= '0;
        end else begin
            level_q <= {1'b0, mem_count_nxt}
                     + {{(ADDR_WIDTH+1){1'b0}}, issue}
                     + {{ADDR_WIDTH{1'b0}}, ob_count_nxt};
        end
    end

    assign level       = level_q;
    assign almost_full = (mem_count >= AF_THRESH);
`endif

endmodule

// File: tb/tb_freepdk45_sram_1w1r_fifo_ctrl.sv
// tb_freepdk45_sram_1w1r_fifo_ctrl
//
// Purpose:
//   Self-checking bench for freepdk45_sram_1w1r_fifo_ctrl. Holds a small SRAM
//   model, a queue-based reference FIFO checked every cycle, and directed
//   sequences with hand-computed expectations (latency, fill to capacity,
//   streaming with pointer wrap, random backpressure, mid-operation reset).
//   Level/almost_full checks are built only with SRAM_FIFO_LEVEL_EN.

module tb_freepdk45_sram_1w1r_fifo_ctrl;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int NM    = 2;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          csb0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
`ifdef SRAM_FIFO_LEVEL_EN
    logic [AW+1:0] level;
    logic          almost_full;
`endif

    freepdk45_sram_1w1r_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_WMASKS(NM)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .csb0(csb0),
        .wmask0(wmask0),
        .addr0(addr0),
        .din0(din0),
        .csb1(csb1),
        .addr1(addr1),
        .dout1(dout1)
`ifdef SRAM_FIFO_LEVEL_EN
        ,
        .level(level),
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: read data appears after the issue edge and is replaced by
    // garbage one cycle later, so only a correctly-timed capture sees it.
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (!csb0) begin
            mem[addr0] <= din0;
        end
        if (!csb1) begin
            dout1 <= mem[addr1];
        end else begin
            dout1 <= {$urandom, $urandom};
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [63:0] data, input bit ready);
        @(posedge clk);
        #1;
        in_valid  = valid;
        in_data   = data;
        out_ready = ready;
    endtask

    // Reference model: ordered queue of accepted words plus write/read
    // address counters. Owned entirely by the compare process.
    logic [DW-1:0] exp_q[$];
    int            push_total = 0;
    int            read_total = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            check_en = 1'b0;
    bit            m_push;
    bit            m_pop;

    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
            push_total = 0;
            read_total = 0;
            stall_prev = 1'b0;
        end else if (check_en) begin
            m_push = in_valid && in_ready;
            m_pop  = out_valid && out_ready;

            checkOutput("csb0", 64'(csb0), 64'(!m_push));
            if (m_push) begin
                checkOutput("addr0", 64'(addr0), 64'(push_total % DEPTH));
                checkOutput("din0", din0, in_data);
                checkOutput("wmask0", 64'(wmask0), 64'(2'b11));
            end

            if (!csb1) begin
                checkOutput("addr1", 64'(addr1), 64'(read_total % DEPTH));
                checkOutput("read_has_data", 64'(read_total < push_total), 64'(1));
                if (!csb0) begin
                    checkOutput("addr_clash", 64'(addr0 == addr1), 64'(0));
                end
                read_total++;
            end

            if (exp_q.size() < DEPTH) begin
                checkOutput("in_ready_room", 64'(in_ready), 64'(1));
            end else if (exp_q.size() >= DEPTH + 2) begin
                checkOutput("in_ready_full", 64'(in_ready), 64'(0));
            end

            if (out_valid) begin
                checkOutput("out_valid_nonempty", 64'(exp_q.size() != 0), 64'(1));
            end

            if (stall_prev) begin
                checkOutput("stall_valid", 64'(out_valid), 64'(1));
                checkOutput("stall_data", out_data, prev_data);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;

            if (m_pop && exp_q.size() != 0) begin
                checkOutput("out_data", out_data, exp_q.pop_front());
            end
            if (m_push) begin
                exp_q.push_back(in_data);
                push_total++;
            end
        end
    end

    // Asserts reset one tick after an edge, checks the write/read selects drop
    // immediately, checks all reset values, then releases away from an edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        check_en = 1'b0;
        rstb     = 1'b0;
        #1;
        checkOutput("rst_csb0_now", 64'(csb0), 64'(1));
        checkOutput("rst_csb1_now", 64'(csb1), 64'(1));
        checkOutput("rst_out_valid_now", 64'(out_valid), 64'(0));
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_csb0", 64'(csb0), 64'(1));
        checkOutput("rst_csb1", 64'(csb1), 64'(1));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_addr0", 64'(addr0), 64'(0));
        checkOutput("rst_addr1", 64'(addr1), 64'(0));
        checkOutput("rst_wmask0", 64'(wmask0), 64'(0));
        checkOutput("rst_din0", din0, 64'(0));
        checkOutput("rst_out_data", out_data, 64'(0));
        rstb = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'(1));
        check_en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [DW-1:0] got[$];
        int            n;

        $display("[TB] start");

        // Single-word latency: push cycle 0, read issue cycle 1, valid cycle 3.
        do_reset();
        applyStimulus(1'b1, 64'hA5A5_0000_0000_0001, 1'b1);
        @(negedge clk);
        checkOutput("lat_c0_csb0", 64'(csb0), 64'(0));
        checkOutput("lat_c0_addr0", 64'(addr0), 64'(0));
        applyStimulus(1'b0, 64'(0), 1'b1);
        @(negedge clk);
        checkOutput("lat_c1_csb1", 64'(csb1), 64'(0));
        checkOutput("lat_c1_addr1", 64'(addr1), 64'(0));
        applyStimulus(1'b0, 64'(0), 1'b1);
        @(negedge clk);
        checkOutput("lat_c2_out_valid", 64'(out_valid), 64'(0));
        applyStimulus(1'b0, 64'(0), 1'b1);
        @(negedge clk);
        checkOutput("lat_c3_out_valid", 64'(out_valid), 64'(1));
        checkOutput("lat_c3_out_data", out_data, 64'hA5A5_0000_0000_0001);
        applyStimulus(1'b0, 64'(0), 1'b1);

        // Fill to DEPTH+2 with the consumer stalled, then drain without gaps.
        do_reset();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, 64'(n), 1'b0);
            @(negedge clk);
            if (c < 34) begin
                checkOutput("fill_ready", 64'(in_ready), 64'(1));
            end
            if (in_valid && in_ready) begin
                n++;
            end
        end
        checkOutput("fill_count", 64'(n), 64'(34));
        checkOutput("fill_full_ready", 64'(in_ready), 64'(0));
        for (int k = 0; k < 36; k++) begin
            applyStimulus(1'b0, 64'(0), 1'b1);
            @(negedge clk);
            checkOutput("drain_valid", 64'(out_valid), 64'(k < 34));
            if (k < 34) begin
                checkOutput("drain_data", out_data, 64'(k));
            end
        end

        // Streaming 100 words at full rate; both pointers wrap 31 -> 0.
        do_reset();
        for (int c = 0; c < 106; c++) begin
            applyStimulus(c < 100, 64'(c), 1'b1);
            @(negedge clk);
            checkOutput("stream_valid", 64'(out_valid), 64'(c >= 3 && c <= 102));
            if (c >= 3 && c <= 102) begin
                checkOutput("stream_data", out_data, 64'(c - 3));
            end
            if (c < 100) begin
                checkOutput("stream_ready", 64'(in_ready), 64'(1));
            end
            if (c == 32) begin
                checkOutput("addr0_wrap", 64'(addr0), 64'(0));
            end
            if (c == 33) begin
                checkOutput("addr1_wrap_csb1", 64'(csb1), 64'(0));
                checkOutput("addr1_wrap", 64'(addr1), 64'(0));
            end
        end

        // Random traffic with roughly 50% backpressure; the model checks it.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 60; c++) begin
            applyStimulus(1'b0, 64'(0), 1'b1);
        end
        @(negedge clk);
        checkOutput("random_drain_empty", 64'(exp_q.size()), 64'(0));
        checkOutput("random_drain_valid", 64'(out_valid), 64'(0));

        // Reset with words stored and a read in flight, then fresh traffic.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 64'(100 + i), 1'b0);
        end
        applyStimulus(1'b0, 64'(0), 1'b0);
        applyStimulus(1'b1, 64'(200), 1'b1);
        do_reset();
        got.delete();
        for (int c = 0; c < 14; c++) begin
            applyStimulus(c < 2, (c == 0) ? 64'h11 : 64'h22, 1'b1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                got.push_back(out_data);
            end
        end
        checkOutput("post_reset_count", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            checkOutput("post_reset_word0", got[0], 64'h11);
            checkOutput("post_reset_word1", got[1], 64'h22);
        end

`ifdef SRAM_FIFO_LEVEL_EN
        // 30 words with the consumer stalled: two sit in the skid buffer.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 64'(i), 1'b0);
        end
        repeat (3) applyStimulus(1'b0, 64'(0), 1'b0);
        @(negedge clk);
        checkOutput("level_30", 64'(level), 64'(30));
        checkOutput("almost_full_28", 64'(almost_full), 64'(0));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 64'(30 + i), 1'b0);
        end
        repeat (2) applyStimulus(1'b0, 64'(0), 1'b0);
        @(negedge clk);
        checkOutput("level_32", 64'(level), 64'(32));
        checkOutput("almost_full_30", 64'(almost_full), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
